// File: rtl/lcd_refresh_ctrl_if.sv
// Signal bundle between the LCD refresh sequencer, its display-list ROM and the LCD pins.
// The master side is the sequencer; the slave side is the ROM/LCD environment.
interface lcd_refresh_ctrl_if;
   logic       en;
   logic [7:0] char_in;
   logic [4:0] index;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       init_done;
   logic       frame_done;

   modport master (
      input  en, char_in,
      output index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
   );

   modport slave (
      output en, char_in,
      input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done
   );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 refresh sequencer: power-on init, then repeated DDRAM writes of a 32-entry display list.
// All outputs are registered; one shared 20-bit down-counter times every wait.
module lcd_refresh_ctrl #(
   parameter int unsigned E_PULSE      = 2,
   parameter int unsigned CMD_WAIT     = 3,
   parameter int unsigned CLEAR_WAIT   = 5,
   parameter int unsigned INIT_WAIT    = 10,
   parameter int unsigned REFRESH_WAIT = 4
) (
   input logic                clk,
   input logic                rst,
   lcd_refresh_ctrl_if.master bus
);
   localparam logic [19:0] EP  = 20'(E_PULSE);
   localparam logic [19:0] CW  = 20'(CMD_WAIT);
   localparam logic [19:0] CLW = 20'(CLEAR_WAIT);
   localparam logic [19:0] IW  = 20'(INIT_WAIT);
   localparam logic [19:0] RW  = 20'(REFRESH_WAIT);

   typedef enum logic [2:0] {
      S_POWER_WAIT, S_SETUP, S_PULSE, S_HOLD, S_FETCH, S_IDLE, S_REFRESH
   } state_t;

   // Which transaction the shared SETUP/PULSE/HOLD states are currently carrying.
   typedef enum logic [1:0] {K_INIT, K_ADDR1, K_CHAR, K_ADDR2} kind_t;

   state_t      state, state_n;
   kind_t       kind, kind_n;
   logic [1:0]  step, step_n;
   logic [19:0] cnt, cnt_n;
   logic [4:0]  index_q, index_n;
   logic        e_q, e_n, rs_q, rs_n, idn_q, idn_n, fd_q, fd_n;
   logic [7:0]  data_q, data_n;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_POWER_WAIT;
         kind    <= K_INIT;
         step    <= '0;
         cnt     <= IW;
         index_q <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= '0;
         idn_q   <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state   <= state_n;
         kind    <= kind_n;
         step    <= step_n;
         cnt     <= cnt_n;
         index_q <= index_n;
         e_q     <= e_n;
         rs_q    <= rs_n;
         data_q  <= data_n;
         idn_q   <= idn_n;
         fd_q    <= fd_n;
      end
   end

   // Each wait state lasts exactly its loaded count: leave on the edge where cnt is 1.
   always_comb begin
      state_n = state;
      kind_n  = kind;
      step_n  = step;
      cnt_n   = cnt;
      index_n = index_q;
      e_n     = e_q;
      rs_n    = rs_q;
      data_n  = data_q;
      idn_n   = idn_q;
      fd_n    = 1'b0;
      unique case (state)
         S_POWER_WAIT: begin
            if (cnt == 20'd1) begin
               state_n = S_SETUP;
               kind_n  = K_INIT;
               step_n  = '0;
               rs_n    = 1'b0;
               data_n  = init_cmd(2'd0);
            end else cnt_n = cnt - 20'd1;
         end
         S_SETUP: begin
            state_n = S_PULSE;
            e_n     = 1'b1;
            cnt_n   = EP;
         end
         S_PULSE: begin
            if (cnt == 20'd1) begin
               state_n = S_HOLD;
               e_n     = 1'b0;
               cnt_n   = (kind == K_INIT && step == 2'd3) ? CLW : CW;
            end else cnt_n = cnt - 20'd1;
         end
         S_HOLD: begin
            if (cnt == 20'd1) begin
               unique case (kind)
                  K_INIT: begin
                     if (step == 2'd3) begin
                        idn_n   = 1'b1;
                        state_n = S_IDLE;
                     end else begin
                        step_n  = step + 2'd1;
                        state_n = S_SETUP;
                        data_n  = init_cmd(step + 2'd1);
                     end
                  end
                  K_ADDR1, K_ADDR2: begin
                     // ADDR1 already zeroed the index; ADDR2 follows index 15.
                     if (kind == K_ADDR2) index_n = index_q + 5'd1;
                     kind_n  = K_CHAR;
                     state_n = S_FETCH;
                     cnt_n   = 20'd2;
                  end
                  K_CHAR: begin
                     if (index_q == 5'd31) begin
                        state_n = S_REFRESH;
                        cnt_n   = RW;
                        fd_n    = 1'b1;
                     end else if (index_q == 5'd15) begin
                        state_n = S_SETUP;
                        kind_n  = K_ADDR2;
                        rs_n    = 1'b0;
                        data_n  = 8'hC0;
                     end else begin
                        state_n = S_FETCH;
                        cnt_n   = 20'd2;
                        index_n = index_q + 5'd1;
                     end
                  end
               endcase
            end else cnt_n = cnt - 20'd1;
         end
         S_FETCH: begin
            if (cnt == 20'd1) begin
               state_n = S_SETUP;
               rs_n    = 1'b1;
               data_n  = bus.char_in;
            end else cnt_n = cnt - 20'd1;
         end
         S_IDLE: begin
            if (bus.en) begin
               state_n = S_SETUP;
               kind_n  = K_ADDR1;
               rs_n    = 1'b0;
               data_n  = 8'h80;
               index_n = '0;
            end
         end
         S_REFRESH: begin
            if (cnt == 20'd1) state_n = S_IDLE;
            else cnt_n = cnt - 20'd1;
         end
         default: state_n = S_POWER_WAIT;
      endcase
   end

   assign bus.index      = index_q;
   assign bus.lcd_e      = e_q;
   assign bus.lcd_rs     = rs_q;
   assign bus.lcd_rw     = 1'b0;
   assign bus.lcd_data   = data_q;
   assign bus.init_done  = idn_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl: a default-parameter instance and a minimum-wait instance.
// Expected writes are queued as stimulus is issued and popped on every lcd_e rise.
module tb_lcd_refresh_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      logic [8:0] rd;
      int         gap;
   } ent_t;

   ent_t sbq [2][$];
   int   fdq [2][$];
   int   ep  [2] = '{2, 1};
   int   cw  [2] = '{3, 1};
   int   clw [2] = '{5, 1};
   int   rfw [2] = '{4, 4};

   logic       prev_e [2];
   logic       prev_idn [2];
   logic [8:0] prev_rd [2];
   int         chg_cyc [2], rise_cyc [2], fall_cyc [2];
   int         pulses [2], first_rise [2], idn_cyc [2];
   int         start, found;

   lcd_refresh_ctrl_if bus ();
   lcd_refresh_ctrl_if bus2 ();

   lcd_refresh_ctrl #(
      .E_PULSE(2), .CMD_WAIT(3), .CLEAR_WAIT(5), .INIT_WAIT(10), .REFRESH_WAIT(4)
   ) dut (.clk(clk), .rst(rst), .bus(bus));

   lcd_refresh_ctrl #(
      .E_PULSE(1), .CMD_WAIT(1), .CLEAR_WAIT(1), .INIT_WAIT(1), .REFRESH_WAIT(4)
   ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) cyc <= 0;
      else cyc <= cyc + 1;
   end

   // Display-list ROM model: registered, entry n holds 'A'+n.
   always @(posedge clk) begin
      bus.char_in  <= {3'b000, bus.index} + 8'h41;
      bus2.char_in <= {3'b000, bus2.index} + 8'h41;
   end

   task automatic chk(input int d, input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL dut%0d %s: observed %0d, expected %0d", d, tag, obs, exp);
      end
   endtask

   task automatic mon(input int d, input logic e, input logic [8:0] rd,
                      input logic idn, input logic fd);
      ent_t x;
      if (!rst) begin
         prev_e[d]     = 1'b0;
         prev_idn[d]   = 1'b0;
         prev_rd[d]    = '0;
         chg_cyc[d]    = 0;
         rise_cyc[d]   = 0;
         fall_cyc[d]   = 0;
         pulses[d]     = 0;
         first_rise[d] = -1;
         idn_cyc[d]    = -1;
      end else begin
         if (rd !== prev_rd[d]) chg_cyc[d] = cyc;
         if (e && !prev_e[d]) begin
            pulses[d]++;
            rise_cyc[d] = cyc;
            if (pulses[d] == 1) first_rise[d] = cyc;
            chk(d, "setup_before_rise", cyc - chg_cyc[d], 1);
            chk(d, "sb_nonempty", int'(sbq[d].size() > 0), 1);
            if (sbq[d].size() > 0) begin
               x = sbq[d].pop_front();
               chk(d, "write_rs_data", int'(rd), int'(x.rd));
               if (x.gap != 0) chk(d, "low_gap", cyc - fall_cyc[d], x.gap);
            end
         end
         if (!e && prev_e[d]) begin
            chk(d, "pulse_width", cyc - rise_cyc[d], ep[d]);
            fall_cyc[d] = cyc;
         end
         if (idn && !prev_idn[d]) begin
            chk(d, "clear_hold", cyc - fall_cyc[d], clw[d]);
            idn_cyc[d] = cyc;
         end
         if (fd) fdq[d].push_back(cyc);
         prev_e[d]   = e;
         prev_idn[d] = idn;
         prev_rd[d]  = rd;
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus.lcd_e, {bus.lcd_rs, bus.lcd_data}, bus.init_done, bus.frame_done);
      mon(1, bus2.lcd_e, {bus2.lcd_rs, bus2.lcd_data}, bus2.init_done, bus2.frame_done);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) step();
   endtask

   task automatic push_init(input int d);
      logic [7:0] ic [4];
      ent_t x;
      ic = '{8'h38, 8'h0C, 8'h06, 8'h01};
      for (int i = 0; i < 4; i++) begin
         x.rd  = {1'b0, ic[i]};
         x.gap = (i == 0) ? 0 : cw[d] + 1;
         sbq[d].push_back(x);
      end
   endtask

   task automatic push_frame(input int d, input int first_gap);
      ent_t x;
      x.rd  = 9'h080;
      x.gap = first_gap;
      sbq[d].push_back(x);
      for (int i = 0; i < 32; i++) begin
         if (i == 16) begin
            x.rd  = 9'h0C0;
            x.gap = cw[d] + 1;
            sbq[d].push_back(x);
         end
         x.rd  = {1'b1, 8'(i + 'h41)};
         x.gap = cw[d] + 3;
         sbq[d].push_back(x);
      end
   endtask

   task automatic wait_fd(input int d, input int n, input int budget);
      for (int i = 0; i < budget && fdq[d].size() < n; i++) step();
   endtask

   function automatic int fdd(input int d, input int i);
      if (i < fdq[d].size()) return fdq[d][i];
      return -100000;
   endfunction

   function automatic int outs0();
      return int'({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data,
                   bus.index, bus.init_done, bus.frame_done});
   endfunction

   task automatic init_phase();
      push_init(0);
      push_init(1);
      rst = 1'b1;
      for (int i = 0; i < 100 && !bus.init_done; i++) step();
      chk(0, "init_done_cycle", bus.init_done ? cyc : -1, 36);
      chk(0, "first_e_rise", first_rise[0], 11);
      chk(1, "init_done_cycle", idn_cyc[1], 13);
      chk(1, "first_e_rise", first_rise[1], 2);
      cycles(40);
      chk(0, "init_pulse_count", pulses[0], 4);
      chk(1, "init_pulse_count", pulses[1], 4);
      chk(0, "sb_drained", sbq[0].size(), 0);
   endtask

   initial begin
      rst      = 1'b0;
      bus.en   = 1'b0;
      bus2.en  = 1'b0;
      cycles(3);
      chk(0, "reset_outputs", outs0(), 0);
      chk(1, "reset_outputs", int'({bus2.lcd_e, bus2.lcd_rs, bus2.lcd_data, bus2.index,
                                    bus2.init_done, bus2.frame_done}), 0);

      // Power-on init with en low: four commands, then silence.
      init_phase();

      // One frame from a single-cycle en.
      fdq[0].delete();
      push_frame(0, 0);
      bus.en = 1'b1;
      start  = cyc + 1;
      step();
      bus.en = 1'b0;
      wait_fd(0, 1, 400);
      chk(0, "frame_length", fdd(0, 0) - start, 268);
      cycles(20);
      chk(0, "frame_done_cycles", fdq[0].size(), 1);
      chk(0, "index_holds_31", int'(bus.index), 31);
      chk(0, "lcd_rw", int'(bus.lcd_rw), 0);
      chk(0, "sb_drained", sbq[0].size(), 0);

      // en held high: back-to-back frames, then en dropped mid-frame at index 10.
      fdq[0].delete();
      push_frame(0, 0);
      for (int f = 0; f < 3; f++) push_frame(0, cw[0] + rfw[0] + 2);
      bus.en = 1'b1;
      start  = cyc + 1;
      wait_fd(0, 3, 1000);
      for (int i = 0; i < 400 && bus.index != 5'd10; i++) step();
      chk(0, "index_10_reached", int'(bus.index), 10);
      bus.en = 1'b0;
      wait_fd(0, 4, 400);
      cycles(300);
      chk(0, "frame_done_count", fdq[0].size(), 4);
      chk(0, "frame1_length", fdd(0, 0) - start, 268);
      for (int f = 1; f < 4; f++) chk(0, "frame_period", fdd(0, f) - fdd(0, f - 1), 273);
      chk(0, "sb_drained", sbq[0].size(), 0);
      chk(0, "index_holds_31", int'(bus.index), 31);

      // Reset during the PULSE of character 20, then full re-init.
      push_frame(0, 0);
      bus.en = 1'b1;
      step();
      bus.en = 1'b0;
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         if (bus.index == 5'd20 && bus.lcd_e) found = 1;
         else step();
      end
      chk(0, "char20_pulse_found", found, 1);
      rst = 1'b0;
      step();
      chk(0, "midframe_reset_outputs", outs0(), 0);
      sbq[0].delete();
      sbq[1].delete();
      fdq[0].delete();
      fdq[1].delete();
      cycles(2);
      init_phase();

      // Minimum-wait instance: one frame.
      push_frame(1, 0);
      bus2.en = 1'b1;
      start   = cyc + 1;
      step();
      bus2.en = 1'b0;
      wait_fd(1, 1, 300);
      chk(1, "frame_length", fdd(1, 0) - start, 166);
      cycles(20);
      chk(1, "frame_done_cycles", fdq[1].size(), 1);
      chk(1, "sb_drained", sbq[1].size(), 0);
      chk(1, "index_holds_31", int'(bus2.index), 31);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
